// File: rtl/ipm2t_hssthp_lpll_pkg.sv
// ----------------------------------------------------------------------------
// ipm2t_hssthp_lpll_pkg
// Shared definitions for the multi-channel LPLL reset sequencer: the channel
// state enumeration and the timing constants derived from the free-running
// clock frequency (in MHz).
// ----------------------------------------------------------------------------
package ipm2t_hssthp_lpll_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POWERUP   = 3'd1,
    WAIT_LOCK = 3'd2,
    QUAL      = 3'd3,
    DONE      = 3'd4,
    FAIL      = 3'd5
  } lpll_state_e;

  // Powerdown release point, 30 us into POWERUP.
  function automatic int pd_cyc(input int f);
    return 32'sd30 * f;
  endfunction

  // Reset pulse start, floor(30.15 us * f).
  function automatic int rst_on_cyc(input int f);
    return (32'sd3015 * f) / 32'sd100;
  endfunction

  // Reset pulse end and POWERUP exit, floor(38.15 us * f).
  function automatic int rst_off_cyc(input int f);
    return (32'sd3815 * f) / 32'sd100;
  endfunction

  // Lock qualification window, 2 us.
  function automatic int qual_cyc(input int f);
    return 32'sd2 * f;
  endfunction

  // Lock-wait timeout.
  function automatic int tmo_cyc(input int f, input int us);
    return us * f;
  endfunction

  // Counter width large enough for the longest interval timed by one counter.
  function automatic int cntr_w(input int f, input int us);
    int longest;
    longest = (rst_off_cyc(f) > tmo_cyc(f, us)) ? rst_off_cyc(f) : tmo_cyc(f, us);
    return $clog2(longest + 32'sd1);
  endfunction

endpackage

// File: rtl/ipm2t_hssthp_lpll_chan_fsm.sv
// ----------------------------------------------------------------------------
// ipm2t_hssthp_lpll_chan_fsm
// One LPLL power-up / reset sequencer channel: lock synchroniser, sequencing
// FSM, shared interval counter and timeout retry counter.
//
// Ports:
//   clk          free-running clock
//   rst          synchronous active-high reset
//   pll_lock_i   raw LPLL lock (asynchronous)
//   rst_req_i    software re-reset pulse for this channel
//   powerdown_o  LPLL powerdown (registered)
//   lpll_rst_o   LPLL reset (registered)
//   done_o       channel locked and qualified (registered)
//   fail_o       sticky, retries exhausted (registered)
// ----------------------------------------------------------------------------
module ipm2t_hssthp_lpll_chan_fsm
  import ipm2t_hssthp_lpll_pkg::*;
#(
  parameter int FREE_CLOCK_FREQ = 100,
  parameter int LOCK_TIMEOUT_US = 100,
  parameter int MAX_RETRY       = 3,
  parameter int LOCK_LOSS_MON   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock_i,
  input  logic rst_req_i,
  output logic powerdown_o,
  output logic lpll_rst_o,
  output logic done_o,
  output logic fail_o
);

  localparam int CW = cntr_w(FREE_CLOCK_FREQ, LOCK_TIMEOUT_US);

  localparam logic [CW-1:0] PD_C      = CW'(pd_cyc(FREE_CLOCK_FREQ));
  localparam logic [CW-1:0] RST_ON_C  = CW'(rst_on_cyc(FREE_CLOCK_FREQ));
  localparam logic [CW-1:0] RST_OFF_C = CW'(rst_off_cyc(FREE_CLOCK_FREQ));
  localparam logic [CW-1:0] QUAL_M1_C = CW'(qual_cyc(FREE_CLOCK_FREQ) - 32'sd1);
  localparam logic [CW-1:0] TMO_M1_C  = CW'(tmo_cyc(FREE_CLOCK_FREQ, LOCK_TIMEOUT_US) - 32'sd1);
  localparam logic [CW-1:0] CNTR_MAX  = {CW{1'b1}};
  localparam logic [2:0]    MAX_R     = 3'(MAX_RETRY);
  localparam logic          LLM_EN    = (LOCK_LOSS_MON != 32'sd0);

  logic [1:0]    lock_sync_q;
  logic          lock_s;
  lpll_state_e   state_q, state_d;
  logic [CW-1:0] cntr_q, cntr_d, cntr_inc_s;
  logic [2:0]    retry_q, retry_d;
  logic          powerdown_q, powerdown_d;
  logic          lpll_rst_q, lpll_rst_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;

  assign lock_s = lock_sync_q[1];
  // Counter saturates instead of wrapping.
  assign cntr_inc_s = (cntr_q == CNTR_MAX) ? cntr_q : (cntr_q + {{(CW-1){1'b0}}, 1'b1});

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_lock_i};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cntr_q      <= {CW{1'b0}};
      retry_q     <= 3'd0;
      powerdown_q <= 1'b1;
      lpll_rst_q  <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cntr_q      <= cntr_d;
      retry_q     <= retry_d;
      powerdown_q <= powerdown_d;
      lpll_rst_q  <= lpll_rst_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state, counter and retry logic; the software request overrides all.
  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    retry_d = retry_q;
    if (rst_req_i) begin
      state_d = IDLE;
      cntr_d  = {CW{1'b0}};
      retry_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = POWERUP;
          cntr_d  = {CW{1'b0}};
        end
        POWERUP: begin
          if (cntr_q >= RST_OFF_C) begin
            state_d = WAIT_LOCK;
            cntr_d  = {CW{1'b0}};
          end else begin
            cntr_d = cntr_inc_s;
          end
        end
        WAIT_LOCK: begin
          // Terminal count is checked first so a lock arriving on the same
          // cycle still counts as a timeout.
          if (cntr_q >= TMO_M1_C) begin
            cntr_d = {CW{1'b0}};
            if (retry_q < MAX_R) begin
              retry_d = retry_q + 3'd1;
              state_d = IDLE;
            end else begin
              state_d = FAIL;
            end
          end else if (lock_s) begin
            state_d = QUAL;
            cntr_d  = {CW{1'b0}};
          end else begin
            cntr_d = cntr_inc_s;
          end
        end
        QUAL: begin
          // A drop restarts the lock wait without consuming a retry.
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cntr_d  = {CW{1'b0}};
          end else if (cntr_q >= QUAL_M1_C) begin
            state_d = DONE;
            retry_d = 3'd0;
          end else begin
            cntr_d = cntr_inc_s;
          end
        end
        DONE: begin
          retry_d = 3'd0;
          if (LLM_EN && !lock_s) begin
            state_d = IDLE;
            cntr_d  = {CW{1'b0}};
          end else begin
            state_d = DONE;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = IDLE;
          cntr_d  = {CW{1'b0}};
          retry_d = 3'd0;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs move together with it;
  // POWERUP edges are timed by the counter value being left.
  always_comb begin
    powerdown_d = 1'b1;
    lpll_rst_d  = 1'b0;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    case (state_d)
      IDLE: begin
        powerdown_d = 1'b1;
      end
      POWERUP: begin
        if (state_q == POWERUP) begin
          powerdown_d = (cntr_q < PD_C);
          lpll_rst_d  = (cntr_q >= RST_ON_C);
        end else begin
          powerdown_d = 1'b1;
          lpll_rst_d  = 1'b0;
        end
      end
      WAIT_LOCK, QUAL: begin
        powerdown_d = 1'b0;
      end
      DONE: begin
        powerdown_d = 1'b0;
        done_d      = 1'b1;
      end
      FAIL: begin
        fail_d = 1'b1;
      end
      default: begin
        powerdown_d = 1'b1;
      end
    endcase
  end

  assign powerdown_o = powerdown_q;
  assign lpll_rst_o  = lpll_rst_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;

endmodule

// File: rtl/ipm2t_hssthp_multi_lpll_rst_ctrl.sv
// ----------------------------------------------------------------------------
// ipm2t_hssthp_multi_lpll_rst_ctrl
// Multi-channel LPLL power-up / reset sequencer for the HSSTHP wrapper. Each
// LPLL has an independent channel sequencer; the top level only registers the
// aggregate done flag.
//
// Ports:
//   clk               free-running clock, FREE_CLOCK_FREQ MHz
//   rst               synchronous active-high reset
//   i_pll_lock        raw LPLL lock per channel (asynchronous)
//   i_pll_rst_req     per-channel software re-reset pulse
//   o_lpll_powerdown  LPLL powerdown per channel
//   o_lpll_rst        LPLL reset per channel
//   o_lpll_done       channel locked and qualified
//   o_lpll_fail       sticky retries-exhausted flag
//   o_all_done        registered AND of o_lpll_done
// ----------------------------------------------------------------------------
module ipm2t_hssthp_multi_lpll_rst_ctrl
  import ipm2t_hssthp_lpll_pkg::*;
#(
  parameter int NUM_PLL         = 2,
  parameter int FREE_CLOCK_FREQ = 100,
  parameter int LOCK_TIMEOUT_US = 100,
  parameter int MAX_RETRY       = 3,
  parameter int LOCK_LOSS_MON   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_PLL-1:0] i_pll_lock,
  input  logic [NUM_PLL-1:0] i_pll_rst_req,
  output logic [NUM_PLL-1:0] o_lpll_powerdown,
  output logic [NUM_PLL-1:0] o_lpll_rst,
  output logic [NUM_PLL-1:0] o_lpll_done,
  output logic [NUM_PLL-1:0] o_lpll_fail,
  output logic               o_all_done
);

  logic all_done_q;

  for (genvar k = 0; k < NUM_PLL; k++) begin : g_chan
    ipm2t_hssthp_lpll_chan_fsm #(
      .FREE_CLOCK_FREQ (FREE_CLOCK_FREQ),
      .LOCK_TIMEOUT_US (LOCK_TIMEOUT_US),
      .MAX_RETRY       (MAX_RETRY),
      .LOCK_LOSS_MON   (LOCK_LOSS_MON)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .pll_lock_i  (i_pll_lock[k]),
      .rst_req_i   (i_pll_rst_req[k]),
      .powerdown_o (o_lpll_powerdown[k]),
      .lpll_rst_o  (o_lpll_rst[k]),
      .done_o      (o_lpll_done[k]),
      .fail_o      (o_lpll_fail[k])
    );
  end

  // Aggregate done, one cycle behind the per-channel done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      all_done_q <= 1'b0;
    end else begin
      all_done_q <= &o_lpll_done;
    end
  end

  assign o_all_done = all_done_q;

endmodule

// File: tb/tb_ipm2t_hssthp_multi_lpll_rst_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for ipm2t_hssthp_multi_lpll_rst_ctrl. Two instances share stimulus:
// index 0 monitors lock loss, index 1 ignores it. A timeline model tracks,
// per channel, the age of the current power-up sequence, the elapsed lock
// wait and the run of consecutive synchronised lock samples.
// ----------------------------------------------------------------------------
module tb_ipm2t_hssthp_multi_lpll_rst_ctrl;

  localparam int F       = 10;
  localparam int LT_US   = 30;
  localparam int MAXR    = 3;
  localparam int PD      = 30 * F;
  localparam int RST_ON  = (3015 * F) / 100;
  localparam int RST_OFF = (3815 * F) / 100;
  localparam int QUALC   = 2 * F;
  localparam int TMO     = LT_US * F;

  logic       clk;
  logic       rst;
  logic [1:0] pll_lock;
  logic [1:0] pll_rst_req;
  logic [1:0] o_pd   [2];
  logic [1:0] o_rs   [2];
  logic [1:0] o_dn   [2];
  logic [1:0] o_fl   [2];
  logic       o_all  [2];

  int n_checks;
  int n_fail;
  bit chk_en;

  // model state, [instance][channel]
  int   m_age   [2][2];
  int   m_e     [2][2];
  int   m_run   [2][2];
  int   m_tries [2][2];
  bit   m_done  [2][2];
  bit   m_fail  [2][2];
  bit   m_all   [2];
  logic [1:0] sync1, sync2;

  ipm2t_hssthp_multi_lpll_rst_ctrl #(
    .NUM_PLL(2), .FREE_CLOCK_FREQ(F), .LOCK_TIMEOUT_US(LT_US),
    .MAX_RETRY(MAXR), .LOCK_LOSS_MON(1)
  ) dut (
    .clk(clk), .rst(rst), .i_pll_lock(pll_lock), .i_pll_rst_req(pll_rst_req),
    .o_lpll_powerdown(o_pd[0]), .o_lpll_rst(o_rs[0]), .o_lpll_done(o_dn[0]),
    .o_lpll_fail(o_fl[0]), .o_all_done(o_all[0])
  );

  ipm2t_hssthp_multi_lpll_rst_ctrl #(
    .NUM_PLL(2), .FREE_CLOCK_FREQ(F), .LOCK_TIMEOUT_US(LT_US),
    .MAX_RETRY(MAXR), .LOCK_LOSS_MON(0)
  ) dut_nm (
    .clk(clk), .rst(rst), .i_pll_lock(pll_lock), .i_pll_rst_req(pll_rst_req),
    .o_lpll_powerdown(o_pd[1]), .o_lpll_rst(o_rs[1]), .o_lpll_done(o_dn[1]),
    .o_lpll_fail(o_fl[1]), .o_all_done(o_all[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [1:0] e_pd, e_rs, e_dn, e_fl;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        e_pd[k] = m_fail[i][k] || (m_age[i][k] >= 0 && m_age[i][k] <= PD + 1);
        e_rs[k] = (m_age[i][k] >= RST_ON + 2) && (m_age[i][k] <= RST_OFF + 1);
        e_dn[k] = m_done[i][k];
        e_fl[k] = m_fail[i][k];
      end
      check_eq($sformatf("i%0d_powerdown", i), 32'(o_pd[i]), 32'(e_pd));
      check_eq($sformatf("i%0d_lpll_rst", i),  32'(o_rs[i]), 32'(e_rs));
      check_eq($sformatf("i%0d_done", i),      32'(o_dn[i]), 32'(e_dn));
      check_eq($sformatf("i%0d_fail", i),      32'(o_fl[i]), 32'(e_fl));
      check_eq($sformatf("i%0d_all_done", i),  32'(o_all[i]), 32'(m_all[i]));
    end
  endtask

  // Advance the timeline model by one clock edge with the sampled inputs.
  task automatic model_edge(input logic [1:0] lk, input logic [1:0] rq, input logic r);
    logic [1:0] s;
    s = sync2;
    if (r) begin
      sync1 = 2'b00;
      sync2 = 2'b00;
    end else begin
      sync2 = sync1;
      sync1 = lk;
    end
    for (int i = 0; i < 2; i++) begin
      m_all[i] = r ? 1'b0 : (m_done[i][0] & m_done[i][1]);
      for (int k = 0; k < 2; k++) begin
        if (r || rq[k]) begin
          m_age[i][k] = 0; m_e[i][k] = 0; m_run[i][k] = 0;
          m_tries[i][k] = 0; m_done[i][k] = 1'b0; m_fail[i][k] = 1'b0;
        end else if (m_fail[i][k]) begin
          m_fail[i][k] = 1'b1;
        end else if (m_done[i][k]) begin
          if (i == 0 && !s[k]) begin
            m_done[i][k] = 1'b0;
            m_age[i][k]  = 0;
          end
        end else if (m_age[i][k] >= 0) begin
          m_age[i][k]++;
          if (m_age[i][k] == RST_OFF + 2) begin
            m_age[i][k] = -1; m_e[i][k] = 0; m_run[i][k] = 0;
          end
        end else if (m_run[i][k] == 0) begin
          if (m_e[i][k] == TMO - 1) begin
            if (m_tries[i][k] < MAXR) begin
              m_tries[i][k]++;
              m_age[i][k] = 0;
            end else begin
              m_fail[i][k] = 1'b1;
            end
          end else if (s[k]) begin
            m_run[i][k] = 1;
          end else begin
            m_e[i][k]++;
          end
        end else begin
          if (!s[k]) begin
            m_run[i][k] = 0; m_e[i][k] = 0;
          end else begin
            m_run[i][k]++;
            if (m_run[i][k] == QUALC + 1) begin
              m_done[i][k] = 1'b1; m_tries[i][k] = 0; m_run[i][k] = 0;
            end
          end
        end
      end
    end
  endtask

  // One clock: check at the falling edge, drive, then advance the model.
  task automatic step(input logic [1:0] lk, input logic [1:0] rq, input logic r);
    @(negedge clk);
    if (chk_en) compare_all();
    pll_lock    = lk;
    pll_rst_req = rq;
    rst         = r;
    @(posedge clk);
    model_edge(lk, rq, r);
    chk_en = 1'b1;
  endtask

  task automatic run(input int n, input logic [1:0] lk);
    for (int c = 0; c < n; c++) step(lk, 2'b00, 1'b0);
  endtask

  initial begin
    int t0, t1, h, ch;
    logic [1:0] lk;
    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    sync1 = 2'b00; sync2 = 2'b00;
    rst = 1'b1; pll_lock = 2'b00; pll_rst_req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_all[i] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_age[i][k] = 0; m_e[i][k] = 0; m_run[i][k] = 0;
        m_tries[i][k] = 0; m_done[i][k] = 1'b0; m_fail[i][k] = 1'b0;
      end
    end

    // reset state
    repeat (3) step(2'b00, 2'b00, 1'b1);

    // nominal: each lock arrives at a random point around the lock wait
    t0 = 370 + $urandom_range(0, 120);
    t1 = 370 + $urandom_range(0, 120);
    for (int c = 0; c < 800; c++) step({1'(c >= t1), 1'(c >= t0)}, 2'b00, 1'b0);

    // lock loss in DONE on a random channel
    ch = $urandom_range(0, 1);
    lk = 2'b11; lk[ch] = 1'b0;
    step(lk, 2'b00, 1'b0);
    run(800, 2'b11);

    // glitch during qualification
    step(2'b00, 2'b11, 1'b0);
    run(400, 2'b00);
    h = $urandom_range(3, 15);
    run(h, 2'b11);
    run(1, 2'b00);
    run(300, 2'b11);

    // timeout with retries on ch1 until FAIL, ch0 stays locked
    step(2'b01, 2'b10, 1'b0);
    run(2800, 2'b01);
    // software re-reset from FAIL
    step(2'b01, 2'b10, 1'b0);
    run(350, 2'b01);
    // software re-reset mid-POWERUP while reset pulse is high
    step(2'b01, 2'b10, 1'b0);
    run(400, 2'b01);
    // rst together with a re-reset request mid lock wait
    step(2'b01, 2'b11, 1'b1);
    run(600, 2'b11);

    // random tail
    lk = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] rq;
      logic       r;
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 199) == 0) lk[k] = ~lk[k];
        rq[k] = ($urandom_range(0, 799) == 0);
      end
      r = ($urandom_range(0, 1999) == 0);
      step(lk, rq, r);
    end
    @(negedge clk);
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
